// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the pipeline and hazard_stall_unit.
// The master modport is the pipeline side; the slave modport is the stall unit.
interface hazard_stall_unit_if #(
   parameter int REG_W = 5,
   parameter int OP_W  = 6,
   parameter int CNT_W = 16
);
   logic             ID_Valid;
   logic [OP_W-1:0]  ID_Op;
   logic [REG_W-1:0] ID_rs;
   logic [REG_W-1:0] ID_rt;
   logic             EX_MemRead;
   logic             EX_RegWrite;
   logic [REG_W-1:0] EX_WriteReg;
   logic             MEM_MemRead;
   logic             MEM_MemWrite;
   logic [REG_W-1:0] MEM_WriteReg;
   logic             Mem_Ready;
   logic             PC_WriteEn;
   logic             IFID_WriteEn;
   logic             IDEX_WriteEn;
   logic             EXMEM_WriteEn;
   logic             Stall_flush;
   logic [1:0]       StallCause;
   logic             Mem_Error;
   logic [CNT_W-1:0] Stall_Count;

   modport master (
      output ID_Valid, ID_Op, ID_rs, ID_rt,
             EX_MemRead, EX_RegWrite, EX_WriteReg,
             MEM_MemRead, MEM_MemWrite, MEM_WriteReg, Mem_Ready,
      input  PC_WriteEn, IFID_WriteEn, IDEX_WriteEn, EXMEM_WriteEn,
             Stall_flush, StallCause, Mem_Error, Stall_Count
   );

   modport slave (
      input  ID_Valid, ID_Op, ID_rs, ID_rt,
             EX_MemRead, EX_RegWrite, EX_WriteReg,
             MEM_MemRead, MEM_MemWrite, MEM_WriteReg, Mem_Ready,
      output PC_WriteEn, IFID_WriteEn, IDEX_WriteEn, EXMEM_WriteEn,
             Stall_flush, StallCause, Mem_Error, Stall_Count
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / memory-freeze stall control with timeout FSM and stall counter.
// Define BRANCH_IN_ID_EN to also stall branches whose operands are still in flight.
module hazard_stall_unit #(
   parameter int              REG_W       = 5,
   parameter int              OP_W        = 6,
   parameter logic [OP_W-1:0] OP_SW       = 'h2B,
   parameter logic [OP_W-1:0] OP_BEQ      = 'h04,
   parameter logic [OP_W-1:0] OP_BNE      = 'h05,
   parameter int              MEM_TIMEOUT = 8,
   parameter int              CNT_W       = 16
) (
   input logic                clk,
   input logic                rst_n,
   hazard_stall_unit_if.slave hz
);
   localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [OP_W-1:0] OP_RT  = OP_W'(6'h00);
   localparam logic [OP_W-1:0] OP_J   = OP_W'(6'h02);
   localparam logic [OP_W-1:0] OP_JAL = OP_W'(6'h03);
   localparam logic [OP_W-1:0] OP_LUI = OP_W'(6'h0F);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

   state_t            state, state_n;
   logic [WC_W-1:0]   wcnt, wcnt_n;
   logic [CNT_W-1:0]  stall_cnt;
   logic              rs_used, rt_used, load_use, branch, freeze;
   logic              pc_en, ifid_en, idex_en, exmem_en, flush;
   logic [1:0]        cause;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic reg_match(input logic [REG_W-1:0] r);
      return (r != '0) && ((r == hz.ID_rs && rs_used) || (r == hz.ID_rt && rt_used));
   endfunction

   assign rs_used  = hz.ID_Valid && !(hz.ID_Op inside {OP_J, OP_JAL, OP_LUI});
   assign rt_used  = hz.ID_Valid && (hz.ID_Op inside {OP_RT, OP_SW, OP_BEQ, OP_BNE});
   assign load_use = hz.EX_MemRead && reg_match(hz.EX_WriteReg);
   // ERR masks the freeze so the stuck access is dropped and the pipeline advances.
   assign freeze   = rst_n && (hz.MEM_MemRead || hz.MEM_MemWrite) && !hz.Mem_Ready
                     && (state != ST_ERR);

`ifdef BRANCH_IN_ID_EN
   assign branch = (hz.ID_Op inside {OP_BEQ, OP_BNE}) && !load_use &&
                   ((hz.EX_RegWrite && !hz.EX_MemRead && reg_match(hz.EX_WriteReg)) ||
                    (hz.MEM_MemRead && reg_match(hz.MEM_WriteReg)));
`else
   logic unused_branch_inputs;
   assign branch = 1'b0;
   assign unused_branch_inputs = ^{hz.EX_RegWrite, hz.MEM_WriteReg};
`endif

   always_comb begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      flush    = 1'b0;
      cause    = 2'd0;
      if (!rst_n) begin
         cause = 2'd0;
      end else if (freeze) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         cause    = 2'd3;
      end else if (load_use || branch) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         flush   = 1'b1;
         cause   = load_use ? 2'd1 : 2'd2;
      end
   end

   // wcnt holds the number of frozen cycles already spent, so the freeze lasts
   // exactly MEM_TIMEOUT cycles before the single ERR cycle.
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      case (state)
         ST_RUN: begin
            if (freeze) begin
               if (MEM_TIMEOUT == 1) begin
                  state_n = ST_ERR;
                  wcnt_n  = '0;
               end else begin
                  state_n = ST_WAIT;
                  wcnt_n  = WC_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (!freeze) begin
               state_n = ST_RUN;
               wcnt_n  = '0;
            end else if (wcnt >= WC_LAST) begin
               state_n = ST_ERR;
               wcnt_n  = '0;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_RUN;
            wcnt_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         wcnt      <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign hz.PC_WriteEn    = pc_en;
   assign hz.IFID_WriteEn  = ifid_en;
   assign hz.IDEX_WriteEn  = idex_en;
   assign hz.EXMEM_WriteEn = exmem_en;
   assign hz.Stall_flush   = flush;
   assign hz.StallCause    = cause;
   assign hz.Mem_Error     = rst_n && (state == ST_ERR);
   assign hz.Stall_Count   = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expected control vectors are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_hazard_stall_unit;
   // Control vector: {PC, IFID, IDEX, EXMEM, flush, cause[1:0], Mem_Error}
   localparam logic [7:0] RUNV = 8'b1111_0_00_0;
   localparam logic [7:0] LU   = 8'b0011_1_01_0;
   localparam logic [7:0] FRZ  = 8'b0000_0_11_0;
   localparam logic [7:0] ERRV = 8'b1111_0_00_1;
`ifdef BRANCH_IN_ID_EN
   localparam logic [7:0] BR   = 8'b0011_1_10_0;
`else
   localparam logic [7:0] BR   = RUNV;
`endif

   logic        clk;
   logic        rst_n;
   int          total;
   int          bad;
   logic [15:0] model;
   logic [7:0]  exp_q[$];
   logic [7:0]  e;

   hazard_stall_unit_if #(.REG_W(5), .OP_W(6), .CNT_W(16)) bus ();

   hazard_stall_unit #(.MEM_TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] outv();
      return {bus.PC_WriteEn, bus.IFID_WriteEn, bus.IDEX_WriteEn, bus.EXMEM_WriteEn,
              bus.Stall_flush, bus.StallCause, bus.Mem_Error};
   endfunction

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic exr, input logic exw,
                        input logic [4:0] exwr, input logic mr, input logic mw,
                        input logic [4:0] mwr, input logic rdy);
      bus.ID_Valid     = v;
      bus.ID_Op        = op;
      bus.ID_rs        = rs;
      bus.ID_rt        = rt;
      bus.EX_MemRead   = exr;
      bus.EX_RegWrite  = exw;
      bus.EX_WriteReg  = exwr;
      bus.MEM_MemRead  = mr;
      bus.MEM_MemWrite = mw;
      bus.MEM_WriteReg = mwr;
      bus.Mem_Ready    = rdy;
   endtask

   task automatic idle();
      drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1'b1, 6'h00, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd3, 1'b0);
         exp_q.push_back(RUNV);
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL reset[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         total++;
         if (bus.Stall_Count !== model) begin
            bad++;
            $display("FAIL reset[%0d] count got=%0d want=%0d", i, bus.Stall_Count, model);
         end
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (i == 0) begin
            drive(1'b1, 6'h00, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b1);
            exp_q.push_back(LU);
         end else begin
            idle();
            exp_q.push_back(RUNV);
         end
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL load_use[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         total++;
         if (bus.Stall_Count !== model) begin
            bad++;
            $display("FAIL load_use[%0d] count got=%0d want=%0d", i, bus.Stall_Count, model);
         end
         if (!e[7] && model != 16'hFFFF) model++;
      end
   endtask

   task automatic test_rt_qual();
      logic [5:0] ops[5];
      logic [7:0] exps[5];
      logic       vld[5];
      ops  = '{6'h23, 6'h2B, 6'h00, 6'h02, 6'h00};
      exps = '{RUNV, LU, LU, RUNV, RUNV};
      vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         // Case 3 puts the hazard register in rs of a jump, which reads no rs.
         drive(vld[i], ops[i], (i == 3) ? 5'd9 : 5'd4, 5'd9, 1'b1, 1'b1, 5'd9,
               1'b0, 1'b0, 5'd0, 1'b1);
         exp_q.push_back(exps[i]);
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL rt_qual[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         if (!e[7] && model != 16'hFFFF) model++;
      end
      total++;
      @(negedge clk);
      idle();
      #2;
      if (bus.Stall_Count !== model) begin
         bad++;
         $display("FAIL rt_qual count got=%0d want=%0d", bus.Stall_Count, model);
      end
   endtask

   task automatic test_reg_zero();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1'b1, (i == 0) ? 6'h00 : 6'h2B, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0,
               1'b0, 1'b0, 5'd0, 1'b1);
         exp_q.push_back(RUNV);
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL reg_zero[%0d] ctl got=%b want=%b", i, outv(), e);
         end
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         // A pending load-use must stay hidden behind the freeze, then appear.
         if (i < 4) begin
            drive(1'b1, 6'h00, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd3, i == 3);
            exp_q.push_back((i < 3) ? FRZ : LU);
         end else begin
            idle();
            exp_q.push_back(RUNV);
         end
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL mem_wait[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         total++;
         if (bus.Stall_Count !== model) begin
            bad++;
            $display("FAIL mem_wait[%0d] count got=%0d want=%0d", i, bus.Stall_Count, model);
         end
         if (!e[7] && model != 16'hFFFF) model++;
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, i >= 10);
         if (i < 8 || i == 9) exp_q.push_back(FRZ);
         else if (i == 8)     exp_q.push_back(ERRV);
         else                 exp_q.push_back(RUNV);
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL timeout[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         if (!e[7] && model != 16'hFFFF) model++;
      end
      @(negedge clk);
      idle();
      #2;
      total++;
      if (bus.Stall_Count !== model) begin
         bad++;
         $display("FAIL timeout count got=%0d want=%0d", bus.Stall_Count, model);
      end
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2, i == 5);
         rst_n = (i != 3);
         if (i == 3) model = '0;
         exp_q.push_back((i == 3 || i == 5) ? RUNV : FRZ);
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL reset_mid_wait[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         total++;
         if (bus.Stall_Count !== model) begin
            bad++;
            $display("FAIL reset_mid_wait[%0d] count got=%0d want=%0d", i, bus.Stall_Count, model);
         end
         if (rst_n && !e[7] && model != 16'hFFFF) model++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_branch();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         case (i)
            0: begin
               drive(1'b1, 6'h04, 5'd5, 5'd6, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1);
               exp_q.push_back(BR);
            end
            2: begin
               drive(1'b1, 6'h05, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1);
               exp_q.push_back(LU);
            end
            3: begin
               drive(1'b1, 6'h05, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1);
               exp_q.push_back(BR);
            end
            default: begin
               idle();
               exp_q.push_back(RUNV);
            end
         endcase
         #2;
         e = exp_q.pop_front();
         total++;
         if (outv() !== e) begin
            bad++;
            $display("FAIL branch[%0d] ctl got=%b want=%b", i, outv(), e);
         end
         total++;
         if (bus.Stall_Count !== model) begin
            bad++;
            $display("FAIL branch[%0d] count got=%0d want=%0d", i, bus.Stall_Count, model);
         end
         if (!e[7] && model != 16'hFFFF) model++;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_rt_qual();
      test_reg_zero();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_branch();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
